pipelined_cla_adder: RTL

//  Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready flow control.

---
 rtl/pipelined_cla_adder.sv | 107 ++++++++++
 1 files changed

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: segmented carry-lookahead add/sub, one segment per stage, valid/ready flow control
module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int GROUP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int SEG = WIDTH / STAGES;
  if (WIDTH % STAGES != 0 || (WIDTH / STAGES) % GROUP != 0) begin : g_bad_cfg
    $error("pipelined_cla_adder: WIDTH must split into STAGES segments of whole GROUPs");
  end
  // returns {carries[SEG:0], sum[SEG-1:0]}; each bit's carry is a lookahead term off its group carry-in
  function automatic logic [2*SEG:0] cla(input logic [SEG-1:0] x, input logic [SEG-1:0] y, input logic ci);
    logic [SEG-1:0] g, p;
    logic [SEG:0] c;
    logic t;
    g = x & y;
    p = x ^ y;
    c = '0;
    c[0] = ci;
    for (int q = 0; q < SEG; q += GROUP) begin
      for (int j = 0; j < GROUP; j++) begin
        t = c[q];
        for (int i = 0; i <= j; i++) t = g[q+i] | (p[q+i] & t);
        c[q+j+1] = t;
      end
    end
    return {c, p ^ c[SEG-1:0]};
  endfunction
  logic             advance;
  logic [STAGES-1:0] v_q, c_q, iv, ic;
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] ia [STAGES];
  logic [WIDTH-1:0] ib [STAGES];
  logic [WIDTH-1:0] is [STAGES];
  logic [WIDTH-1:0] ns [STAGES];
  logic [2*SEG:0]   r  [STAGES];
  logic             ovf_q, zero_q, ovf_n, zero_n;
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;
  // stage k consumes stage k-1's registers: upper operand bits skew forward, finished sum bits de-skew forward
  always_comb begin
    ia[0] = a;
    ib[0] = sub ? ~b : b;
    is[0] = '0;
    ic[0] = sub | cin;
    iv[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      ia[k] = a_q[k-1];
      ib[k] = b_q[k-1];
      is[k] = s_q[k-1];
      ic[k] = c_q[k-1];
      iv[k] = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      r[k] = cla(ia[k][k*SEG +: SEG], ib[k][k*SEG +: SEG], ic[k]);
      ns[k] = is[k];
      ns[k][k*SEG +: SEG] = r[k][SEG-1:0];
    end
  end
  assign ovf_n  = r[STAGES-1][2*SEG] ^ r[STAGES-1][2*SEG-1];
  assign zero_n = ns[STAGES-1] == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      v_q    <= iv;
      ovf_q  <= ovf_n;
      zero_q <= zero_n;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= ia[k];
        b_q[k] <= ib[k];
        s_q[k] <= ns[k];
        c_q[k] <= r[k][2*SEG];
      end
    end
  end
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule
